alu_scheduler: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/alu_scheduler.sv | 161 ++++++++++++++++
 tb/tb_alu_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU scheduler: op selects, error code and scheduler FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'b0000,
        SUB = 4'b0001,
        MUL = 4'b0010,
        DIV = 4'b0011
    } alu_op_e;

    localparam logic [7:0] ALU_ERR_CODE = 8'hAC;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one registered-output ALU among NUM_REQ requesters: round-robin accept,
// issue, capture after the ALU's one-cycle latency, then a valid/ready response.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    input  logic [NUM_REQ*4-1:0] req_sel,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_sel,
    input  logic [7:0]           alu_out,
    input  logic                 alu_carry,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [7:0]           resp_result,
    output logic                 resp_carry,
    output logic                 resp_err,
    output logic [15:0]          op_count
);

    sched_state_e state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [7:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [3:0]      op_sel_q, op_sel_d;
    logic [ID_W-1:0] op_id_q, op_id_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [7:0]      resp_result_q, resp_result_d;
    logic            resp_carry_q, resp_carry_d;
    logic            resp_err_q, resp_err_d;
    logic [15:0]     op_count_q, op_count_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic [7:0]         gnt_a, gnt_b;
    logic [3:0]         gnt_sel;
    logic               handshake;
    logic               div_zero;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req  (req_valid),
        .ptr  (ptr_q),
        .grant(grant)
    );

    always_comb begin
        gnt_id  = '0;
        gnt_a   = '0;
        gnt_b   = '0;
        gnt_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_id  = ID_W'(i);
                gnt_a   = req_a[i*8 +: 8];
                gnt_b   = req_b[i*8 +: 8];
                gnt_sel = req_sel[i*4 +: 4];
            end
        end
    end

    // Gated by reset_n so nothing is accepted while reset is held.
    assign req_ready = (reset_n && state_q == IDLE) ? grant : '0;
    assign handshake = |(req_valid & req_ready);
    assign div_zero  = (op_sel_q == DIV) && (op_b_q == 8'h00);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_sel_d      = op_sel_q;
        op_id_d       = op_id_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_carry_d  = resp_carry_q;
        resp_err_d    = resp_err_q;
        op_count_d    = op_count_q;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d  = ISSUE;
                    op_a_d   = gnt_a;
                    op_b_d   = gnt_b;
                    op_sel_d = gnt_sel;
                    op_id_d  = gnt_id;
                    if (int'(gnt_id) == NUM_REQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_id + 1'b1;
                    end
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                state_d       = RESP;
                resp_id_d     = op_id_q;
                resp_result_d = div_zero ? 8'h00 : alu_out;
                resp_err_d    = div_zero || (op_sel_q > 4'b0011);
                resp_carry_d  = (op_sel_q == ADD) && alu_carry;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    if (op_count_q != 16'hFFFF) begin
                        op_count_d = op_count_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_sel_q      <= '0;
            op_id_q       <= '0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_carry_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_sel_q      <= op_sel_d;
            op_id_q       <= op_id_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_carry_q  <= resp_carry_d;
            resp_err_q    <= resp_err_d;
            op_count_q    <= op_count_d;
        end
    end

    assign alu_a       = op_a_q;
    assign alu_b       = op_b_q;
    assign alu_sel     = op_sel_q;
    assign resp_valid  = (state_q == RESP);
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_carry  = resp_carry_q;
    assign resp_err    = resp_err_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed cases plus randomized traffic against
// a transaction-level model; the ALU is modelled here with one cycle of output latency.
module tb_alu_scheduler;

    localparam int N = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req_valid, req_ready;
    logic [N*8-1:0] req_a, req_b;
    logic [N*4-1:0] req_sel;
    logic [7:0]    alu_a, alu_b, alu_out;
    logic [3:0]    alu_sel;
    logic          alu_carry;
    logic          resp_valid, resp_ready;
    logic [1:0]    resp_id;
    logic [7:0]    resp_result;
    logic          resp_carry, resp_err;
    logic [15:0]   op_count;

    int n_vec = 0;
    int n_err = 0;
    int mptr  = 0;
    int mcount = 0;

    logic [7:0] ta [N];
    logic [7:0] tbv[N];
    logic [3:0] ts [N];

    alu_scheduler #(.NUM_REQ(N)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result),
        .resp_carry(resp_carry), .resp_err(resp_err),
        .op_count(op_count)
    );

    always #5 clock = ~clock;

    // ALU stand-in: garbage where the scheduler must ignore or mask the ALU.
    always @(posedge clock) begin
        int s;
        s = 0;
        case (alu_sel)
            4'd0: s = int'(alu_a) + int'(alu_b);
            4'd1: s = (int'(alu_a) - int'(alu_b) + 256) % 256;
            4'd2: s = (int'(alu_a) * int'(alu_b)) % 256;
            4'd3: s = (alu_b == 8'd0) ? int'($urandom_range(1, 255)) : int'(alu_a) / int'(alu_b);
            default: s = 32'hAC;
        endcase
        alu_out   <= 8'(s % 256);
        alu_carry <= (alu_sel == 4'd0) ? (s > 255) : 1'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*8 +: 8]  = ta[i];
            req_b[i*8 +: 8]  = tbv[i];
            req_sel[i*4 +: 4] = ts[i];
        end
    endtask

    task automatic junk();
        req_valid = 4'($urandom);
        for (int i = 0; i < N; i++) begin
            ta[i] = 8'($urandom);
            tbv[i] = 8'($urandom);
            ts[i] = 4'($urandom);
        end
        drive_ops();
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] r;
        r = v;
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic void expect_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                                      output logic [7:0] r, output logic c, output logic e);
        int x;
        c = 1'b0;
        e = 1'b0;
        case (s)
            4'd0: begin x = int'(a) + int'(b); r = 8'(x % 256); c = (x > 255); end
            4'd1: r = 8'((int'(a) - int'(b) + 256) % 256);
            4'd2: r = 8'((int'(a) * int'(b)) % 256);
            4'd3: begin
                if (b == 8'd0) begin r = 8'h00; e = 1'b1; end
                else r = 8'(int'(a) / int'(b));
            end
            default: begin r = 8'hAC; e = 1'b1; end
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction from an IDLE cycle; bp cycles of response backpressure.
    task automatic run_op(input logic [N-1:0] v, input int bp, input bit noisy);
        int w;
        logic [7:0] ea, eb, er;
        logic [3:0] es;
        logic ec, ee;
        req_valid  = v;
        resp_ready = 1'b0;
        drive_ops();
        #1;
        w = pick(v, mptr);
        check("grant", req_ready, 32'(1) << w);
        ea = ta[w]; eb = tbv[w]; es = ts[w];
        expect_op(ea, eb, es, er, ec, ee);
        mptr = (w + 1) % N;
        step();
        if (noisy) junk();
        #1;
        check("issue_a", alu_a, ea);
        check("issue_b", alu_b, eb);
        check("issue_sel", alu_sel, es);
        check("issue_rdy", req_ready, 0);
        check("issue_vld", resp_valid, 0);
        step();
        if (noisy) junk();
        #1;
        check("capt_rdy", req_ready, 0);
        check("capt_vld", resp_valid, 0);
        step();
        for (int j = 0; j <= bp; j++) begin
            resp_ready = (j == bp);
            if (noisy) junk();
            #1;
            check("resp_vld", resp_valid, 1);
            check("resp_id", resp_id, w);
            check("resp_res", resp_result, er);
            check("resp_cy", resp_carry, ec);
            check("resp_err", resp_err, ee);
            check("resp_rdy", req_ready, 0);
            check("cnt_hold", op_count, mcount);
            step();
        end
        mcount++;
        resp_ready = 1'b0;
        req_valid  = '0;
        #1;
        check("post_vld", resp_valid, 0);
        check("post_cnt", op_count, mcount);
    endtask

    initial begin
        reset_n = 1'b0;
        resp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin ta[i] = 8'd1; tbv[i] = 8'd1; ts[i] = 4'd0; end
        drive_ops();
        step(); step();
        #1;
        check("rst_rdy", req_ready, 0);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        check("rst_sel", alu_sel, 0);
        check("rst_vld", resp_valid, 0);
        check("rst_id", resp_id, 0);
        check("rst_res", resp_result, 0);
        check("rst_cy", resp_carry, 0);
        check("rst_err", resp_err, 0);
        check("rst_cnt", op_count, 0);
        req_valid = '0;
        reset_n = 1'b1;
        step();

        // Round-robin with all requesters asserting SUB 9-4.
        for (int i = 0; i < N; i++) begin ta[i] = 8'd9; tbv[i] = 8'd4; ts[i] = 4'd1; end
        for (int k = 0; k < 5; k++) run_op(4'b1111, 0, 1'b0);

        // Single ADD with carry.
        ta[0] = 8'd100; tbv[0] = 8'd200; ts[0] = 4'd0;
        run_op(4'b0001, 0, 1'b1);

        // Divide by zero, then an illegal select.
        ta[2] = 8'd50; tbv[2] = 8'd0; ts[2] = 4'd3;
        run_op(4'b0100, 0, 1'b1);
        ta[2] = 8'd50; tbv[2] = 8'd3; ts[2] = 4'd7;
        run_op(4'b0100, 0, 1'b1);

        // Backpressure on MUL 16*17.
        ta[1] = 8'd16; tbv[1] = 8'd17; ts[1] = 4'd2;
        run_op(4'b0010, 5, 1'b1);

        // Wrap and skip: pointer at 3, requests 0 and 2.
        ta[2] = 8'd3; tbv[2] = 8'd2; ts[2] = 4'd0;
        run_op(4'b0100, 0, 1'b0);
        ta[0] = 8'd7; tbv[0] = 8'd7; ts[0] = 4'd2;
        run_op(4'b0101, 0, 1'b0);
        run_op(4'b0101, 0, 1'b0);

        // Reset while the op sits in CAPTURE.
        ta[1] = 8'd200; tbv[1] = 8'd100; ts[1] = 4'd0;
        drive_ops();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        reset_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("midrst_rdy", req_ready, 0);
        step();
        check("midrst_vld", resp_valid, 0);
        check("midrst_cnt", op_count, 0);
        check("midrst_a", alu_a, 0);
        check("midrst_sel", alu_sel, 0);
        check("midrst_res", resp_result, 0);
        reset_n = 1'b1;
        req_valid = '0;
        mptr = 0;
        mcount = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("no_resp", resp_valid, 0);
            step();
        end
        for (int i = 0; i < N; i++) begin ta[i] = 8'd5; tbv[i] = 8'd6; ts[i] = 4'd2; end
        run_op(4'b1111, 0, 1'b0);

        // Randomized traffic with idle gaps and backpressure.
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                req_valid = '0;
                #1;
                check("idle_rdy", req_ready, 0);
                check("idle_vld", resp_valid, 0);
                step();
            end
            for (int i = 0; i < N; i++) begin
                ta[i]  = 8'($urandom);
                tbv[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
                ts[i]  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            end
            run_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
